// File: rtl/stack_if.sv
// Bundle of request/response, data-memory and register-bank SP signals for stack_controller.
// master = controller side, slave = requester/memory/bank side.
interface stack_if #(
  parameter int DATA_W = 32
);
  logic              op_valid;
  logic              op_ready;
  logic              op_push;
  logic [DATA_W-1:0] op_data;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stack_op;
  logic [DATA_W-1:0] sp_next;
  logic [DATA_W-1:0] sp_cur;

  modport master (
    input  op_valid, op_push, op_data, mem_ack, mem_rdata,
    output op_ready, resp_valid, resp_data, resp_err,
           mem_req, mem_we, mem_addr, mem_wdata, stack_op, sp_next, sp_cur
  );

  modport slave (
    output op_valid, op_push, op_data, mem_ack, mem_rdata,
    input  op_ready, resp_valid, resp_data, resp_err,
           mem_req, mem_we, mem_addr, mem_wdata, stack_op, sp_next, sp_cur
  );
endinterface

// File: rtl/stack_controller.sv
// Full-descending stack controller: owns SP, sequences PUSH/POP to data memory, resyncs bank SP.
// Optional STACK_BOUNDS_CHECK_EN adds overflow/underflow detection (ERR state, STACK_LIMIT param).
//
// state | meaning
// INIT  | after reset; second cycle pulses stack_op with STACK_BASE to resync bank SP
// IDLE  | op_ready=1, waiting for a request
// MEM   | memory request held until mem_ack
// DONE  | resp_valid, stack_op commits new SP
// ERR   | resp_valid with resp_err, SP unchanged (bounds-check build only)
module stack_controller #(
  parameter int DATA_W = 32,
`ifdef STACK_BOUNDS_CHECK_EN
  parameter int unsigned STACK_LIMIT = 64,
`endif
  parameter int unsigned STACK_BASE = 111
) (
  input  logic       clock,
  input  logic       reset_n,
  stack_if.master    bus
);

  localparam logic [2:0] INIT = 3'd0;
  localparam logic [2:0] IDLE = 3'd1;
  localparam logic [2:0] MEM  = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic [2:0] ERR  = 3'd4;
  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(STACK_LIMIT);
`endif
  localparam logic [DATA_W-1:0] BASE = DATA_W'(STACK_BASE);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  logic [2:0]        state;
  logic              init_arm;
  logic [DATA_W-1:0] sp_q;
  logic              req_push;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] sp_step;
  logic              bounds_err;
  logic              in_init_pulse;

  assign sp_step = req_push ? (sp_q - ONE) : (sp_q + ONE);

`ifdef STACK_BOUNDS_CHECK_EN
  assign bounds_err = bus.op_push ? (sp_q == LIMIT) : (sp_q == BASE);
`else
  assign bounds_err = 1'b0;
`endif

  // INIT is held for one extra cycle so the resync pulse never shows while reset is asserted.
  assign in_init_pulse = (state == INIT) && init_arm;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      init_arm <= 1'b0;
      sp_q     <= BASE;
      req_push <= 1'b0;
      req_data <= '0;
      req_addr <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        INIT: begin
          if (init_arm) state <= IDLE;
          else          init_arm <= 1'b1;
        end
        IDLE: begin
          if (bus.op_valid) begin
            req_push <= bus.op_push;
            req_data <= bus.op_data;
            req_addr <= bus.op_push ? (sp_q - ONE) : sp_q;
`ifdef STACK_BOUNDS_CHECK_EN
            state    <= bounds_err ? ERR : MEM;
`else
            state    <= MEM;
`endif
          end
        end
        MEM: begin
          if (bus.mem_ack) begin
            rdata_q <= bus.mem_rdata;
            state   <= DONE;
          end
        end
        DONE: begin
          sp_q  <= sp_step;
          state <= IDLE;
        end
`ifdef STACK_BOUNDS_CHECK_EN
        ERR: state <= IDLE;
`endif
        default: state <= INIT;
      endcase
    end
  end

  assign bus.op_ready   = (state == IDLE);
  assign bus.mem_req    = (state == MEM);
  assign bus.mem_we     = (state == MEM) && req_push;
  assign bus.mem_addr   = (state == MEM) ? req_addr : '0;
  assign bus.mem_wdata  = ((state == MEM) && req_push) ? req_data : '0;
  assign bus.resp_data  = ((state == DONE) && !req_push) ? rdata_q : '0;
`ifdef STACK_BOUNDS_CHECK_EN
  assign bus.resp_valid = (state == DONE) || (state == ERR);
  assign bus.resp_err   = (state == ERR);
`else
  assign bus.resp_valid = (state == DONE) || bounds_err;
  assign bus.resp_err   = bounds_err;
`endif
  assign bus.stack_op   = in_init_pulse || (state == DONE);
  assign bus.sp_next    = in_init_pulse ? BASE : ((state == DONE) ? sp_step : '0);
  assign bus.sp_cur     = sp_q;

endmodule
